systolic_matmul_seq: RTL and testbench

Parametrised successor to the fixed 2x2 systolic top: computes C = A·B for an M×K matrix A and K×N matrix B using an output-stationary rows_p×cols_p PE array. Operands arrive as one serial word stream over a valid/ready port; results drain serially over a valid/yumi port on request. Adds rectangular shapes, arbitrary depth, a configurable accumulator width and an accumulate mode that adds a new product onto the held C.

---
 rtl/systolic_matmul_seq_if.sv | 26 ++
 rtl/systolic_matmul_seq.sv | 150 +++++++++++++++
 tb/tb_systolic_matmul_seq.sv | 232 +++++++++++++++++++++++
 3 files changed

// File: rtl/systolic_matmul_seq_if.sv
// Operand load stream, result drain stream and status for systolic_matmul_seq.
// The master side (producer/consumer) drives the _i signals; the slave side (the array) drives the _o signals.
interface systolic_matmul_seq_if #(
  parameter int width_p     = 8,
  parameter int out_width_p = 32
);
  logic                   valid_i;
  logic [width_p-1:0]     data_i;
  logic                   ready_o;
  logic                   accum_i;
  logic                   flush_i;
  logic                   valid_o;
  logic [out_width_p-1:0] data_o;
  logic                   yumi_i;
  logic                   done_o;

  modport master (
    output valid_i, data_i, accum_i, flush_i, yumi_i,
    input  ready_o, valid_o, data_o, done_o
  );

  modport slave (
    input  valid_i, data_i, accum_i, flush_i, yumi_i,
    output ready_o, valid_o, data_o, done_o
  );
endinterface

// File: rtl/systolic_matmul_seq.sv
// Output-stationary rows_p x cols_p systolic matmul: serial A/B load, T=K+M+N-2 compute cycles, done pulse one cycle later.
// Load is valid/ready (one word per cycle), drain is valid/yumi; en_i=0 freezes everything and masks ready_o/valid_o.
module systolic_matmul_seq #(
  parameter int width_p     = 8,
  parameter int out_width_p = 32,
  parameter int rows_p      = 2,
  parameter int cols_p      = 2,
  parameter int depth_p     = 2
) (
  input  logic                clk_i,
  input  logic                reset_i,
  input  logic                en_i,
  systolic_matmul_seq_if.slave io
);
  localparam int L   = rows_p*depth_p + depth_p*cols_p;
  localparam int MN  = rows_p*cols_p;
  localparam int T   = depth_p + rows_p + cols_p - 2;
  localparam int BO  = rows_p*depth_p;
  localparam int LW  = (L > 1) ? $clog2(L) : 1;
  localparam int PW  = (MN > 1) ? $clog2(MN) : 1;
  localparam int IW  = (LW > PW) ? LW : PW;
  localparam int CW  = (T > 1) ? $clog2(T) : 1;

  typedef enum logic [1:0] {IDLE, LOAD, COMPUTE, DRAIN} state_e;

  state_e                 state_q;
  logic [IW-1:0]          idx_q;
  logic [CW-1:0]          cnt_q;
  logic                   accum_q;
  logic                   done_q;
  logic [width_p-1:0]     buf_q [L];
  logic [width_p-1:0]     a_q   [rows_p][cols_p];
  logic [width_p-1:0]     b_q   [rows_p][cols_p];
  logic [out_width_p-1:0] acc_q [MN];

  logic [width_p-1:0]     a_edge_d [rows_p];
  logic [width_p-1:0]     b_edge_d [cols_p];
  logic [width_p-1:0]     a_in_d   [rows_p][cols_p];
  logic [width_p-1:0]     b_in_d   [rows_p][cols_p];
  logic [2*width_p-1:0]   prod_d   [rows_p][cols_p];

  // Row i sees A[i][cnt-i], column j sees B[cnt-j][j]; zero outside the skew window.
  always_comb begin
    for (int i = 0; i < rows_p; i++) begin
      a_edge_d[i] = '0;
      if (int'(cnt_q) >= i && int'(cnt_q) - i < depth_p)
        a_edge_d[i] = buf_q[LW'(i*depth_p + int'(cnt_q) - i)];
    end
    for (int j = 0; j < cols_p; j++) begin
      b_edge_d[j] = '0;
      if (int'(cnt_q) >= j && int'(cnt_q) - j < depth_p)
        b_edge_d[j] = buf_q[LW'(BO + (int'(cnt_q) - j)*cols_p + j)];
    end
    for (int i = 0; i < rows_p; i++) begin
      a_in_d[i][0] = a_edge_d[i];
      for (int j = 1; j < cols_p; j++)
        a_in_d[i][j] = a_q[i][j-1];
    end
    for (int j = 0; j < cols_p; j++) begin
      b_in_d[0][j] = b_edge_d[j];
      for (int i = 1; i < rows_p; i++)
        b_in_d[i][j] = b_q[i-1][j];
    end
    for (int i = 0; i < rows_p; i++)
      for (int j = 0; j < cols_p; j++)
        prod_d[i][j] = a_in_d[i][j] * b_in_d[i][j];
  end

  always_ff @(posedge clk_i or negedge reset_i) begin
    if (!reset_i) begin
      state_q <= IDLE;
      idx_q   <= '0;
      cnt_q   <= '0;
      accum_q <= 1'b0;
      done_q  <= 1'b0;
      for (int n = 0; n < L; n++) buf_q[n] <= '0;
      for (int n = 0; n < MN; n++) acc_q[n] <= '0;
      for (int i = 0; i < rows_p; i++)
        for (int j = 0; j < cols_p; j++) begin
          a_q[i][j] <= '0;
          b_q[i][j] <= '0;
        end
    end else if (en_i) begin
      done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          // A word arriving with flush_i wins; the flush is dropped.
          if (io.valid_i) begin
            buf_q[0] <= io.data_i;
            accum_q  <= io.accum_i;
            idx_q    <= IW'(1);
            state_q  <= LOAD;
          end else if (io.flush_i) begin
            idx_q   <= '0;
            state_q <= DRAIN;
          end
        end
        LOAD: begin
          if (io.valid_i) begin
            buf_q[LW'(idx_q)] <= io.data_i;
            if (idx_q == IW'(L-1)) begin
              idx_q   <= '0;
              cnt_q   <= '0;
              state_q <= COMPUTE;
              for (int i = 0; i < rows_p; i++)
                for (int j = 0; j < cols_p; j++) begin
                  a_q[i][j] <= '0;
                  b_q[i][j] <= '0;
                end
              if (!accum_q)
                for (int n = 0; n < MN; n++) acc_q[n] <= '0;
            end else begin
              idx_q <= idx_q + IW'(1);
            end
          end
        end
        COMPUTE: begin
          for (int i = 0; i < rows_p; i++)
            for (int j = 0; j < cols_p; j++) begin
              a_q[i][j] <= a_in_d[i][j];
              b_q[i][j] <= b_in_d[i][j];
              acc_q[i*cols_p + j] <= acc_q[i*cols_p + j] + out_width_p'(prod_d[i][j]);
            end
          if (cnt_q == CW'(T-1)) begin
            state_q <= IDLE;
            done_q  <= 1'b1;
          end else begin
            cnt_q <= cnt_q + CW'(1);
          end
        end
        DRAIN: begin
          if (io.yumi_i) begin
            if (idx_q == IW'(MN-1)) begin
              idx_q   <= '0;
              state_q <= IDLE;
            end else begin
              idx_q <= idx_q + IW'(1);
            end
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign io.ready_o = en_i && (state_q == IDLE || state_q == LOAD);
  assign io.valid_o = en_i && (state_q == DRAIN);
  assign io.data_o  = io.valid_o ? acc_q[PW'(idx_q)] : '0;
  assign io.done_o  = done_q;
endmodule

// File: tb/tb_systolic_matmul_seq.sv
// Randomised bench for systolic_matmul_seq (M=2, K=3, N=2, 8-bit operands, 16-bit wrapping results).
module tb_systolic_matmul_seq;
  localparam int M  = 2;
  localparam int K  = 3;
  localparam int N  = 2;
  localparam int MK = M*K;
  localparam int L  = M*K + K*N;
  localparam int T  = K + M + N - 2;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  logic en = 1'b1;

  systolic_matmul_seq_if #(.width_p(8), .out_width_p(16)) io ();

  systolic_matmul_seq #(
    .width_p(8), .out_width_p(16), .rows_p(M), .cols_p(N), .depth_p(K)
  ) dut (
    .clk_i(clk), .reset_i(reset_n), .en_i(en), .io(io)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int failures = 0;
  int a_m [MK];
  int b_m [K*N];
  int c_m [M*N];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Reference: plain matrix product, 16-bit wrap, optional accumulate onto held C.
  task automatic model_mul(input logic acc);
    for (int i = 0; i < M; i++)
      for (int j = 0; j < N; j++) begin
        int s;
        s = 0;
        for (int k = 0; k < K; k++) s += a_m[i*K+k] * b_m[k*N+j];
        c_m[i*N+j] = acc ? ((c_m[i*N+j] + s) & 'hFFFF) : (s & 'hFFFF);
      end
  endtask

  task automatic load_mats(input logic acc, input int gap, input logic flush_first, output int t_last);
    for (int w = 0; w < L; w++) begin
      int n;
      io.valid_i = 1'b1;
      io.data_i  = 8'((w < MK) ? a_m[w] : b_m[w-MK]);
      io.accum_i = (w == 0) ? acc : 1'($urandom_range(0, 1));
      io.flush_i = flush_first && (w == 0);
      n = 0;
      while (!io.ready_o && n < 20) begin
        step();
        n++;
      end
      chk("load_rdy", io.ready_o, 1);
      step();
      io.valid_i = 1'b0;
      io.flush_i = 1'b0;
      if (flush_first && w == 0) chk("flush_with_word_ignored", io.valid_o, 0);
      if (w != L-1) begin
        if (gap == 1) step();
        else if (gap == 2) repeat ($urandom_range(0, 2)) step();
      end
    end
    t_last = cyc;
  endtask

  task automatic wait_done(input int t_last, input int extra);
    int n;
    n = 0;
    while (!io.done_o && n < 40) begin
      step();
      n++;
    end
    chk("done_latency", 32'(cyc - t_last), 32'(T + extra));
    chk("ready_at_done", io.ready_o, 1);
    step();
    chk("done_one_cycle", io.done_o, 0);
    chk("no_drain_after_done", io.valid_o, 0);
  endtask

  task automatic run_case(input logic acc, input int gap, input logic flush_first,
                          input logic flush_mid, input int freeze);
    int t;
    load_mats(acc, gap, flush_first, t);
    chk("ready_in_compute", io.ready_o, 0);
    if (flush_mid) begin
      io.flush_i = 1'b1;
      step();
      io.flush_i = 1'b0;
    end
    if (freeze > 0) begin
      en = 1'b0;
      #1;
      chk("freeze_cmp_rdy", io.ready_o, 0);
      repeat (freeze) step();
      en = 1'b1;
    end
    wait_done(t, freeze);
    model_mul(acc);
  endtask

  task automatic drain(input int mode);
    io.flush_i = 1'b1;
    step();
    io.flush_i = 1'b0;
    for (int p = 0; p < M*N; p++) begin
      chk("drain_vld", io.valid_o, 1);
      chk("drain_dat", io.data_o, 32'(c_m[p]));
      if (mode == 1)
        repeat (2) begin
          step();
          chk("drain_hold", io.data_o, 32'(c_m[p]));
        end
      if (mode == 2 && p == 1) begin
        en = 1'b0;
        #1;
        chk("freeze_vld", io.valid_o, 0);
        chk("freeze_rdy", io.ready_o, 0);
        repeat (2) step();
        en = 1'b1;
        #1;
        chk("freeze_dat", io.data_o, 32'(c_m[p]));
      end
      io.yumi_i = 1'b1;
      step();
      io.yumi_i = 1'b0;
    end
    chk("drain_end_vld", io.valid_o, 0);
    chk("drain_end_dat", io.data_o, 0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int t;
    io.valid_i = 1'b0;
    io.data_i  = '0;
    io.accum_i = 1'b0;
    io.flush_i = 1'b0;
    io.yumi_i  = 1'b0;
    repeat (3) step();
    chk("rst_ready", io.ready_o, 1);
    chk("rst_valid", io.valid_o, 0);
    chk("rst_data", io.data_o, 0);
    chk("rst_done", io.done_o, 0);
    reset_n = 1'b1;
    step();

    // Known rectangular vector: expect 58, 64, 139, 154.
    a_m = '{1, 2, 3, 4, 5, 6};
    b_m = '{7, 8, 9, 10, 11, 12};
    run_case(1'b0, 0, 1'b0, 1'b0, 0);
    chk("known_c00", 32'(c_m[0]), 58);
    chk("known_c11", 32'(c_m[3]), 154);
    drain(0);
    drain(1);
    run_case(1'b1, 0, 1'b0, 1'b0, 0);
    drain(0);
    run_case(1'b0, 1, 1'b1, 1'b1, 0);
    drain(2);

    // Wrap: 3 * 255 * 255 = 195075 -> 64003 in 16 bits.
    a_m = '{255, 255, 255, 255, 255, 255};
    b_m = '{255, 255, 255, 255, 255, 255};
    run_case(1'b0, 0, 1'b0, 1'b0, 0);
    drain(0);

    for (int r = 0; r < 8; r++) begin
      for (int n = 0; n < MK; n++) a_m[n] = $urandom_range(0, 255);
      for (int n = 0; n < K*N; n++) b_m[n] = $urandom_range(0, 255);
      run_case(1'($urandom_range(0, 1)), $urandom_range(0, 2), 1'($urandom_range(0, 1)),
               1'($urandom_range(0, 1)), $urandom_range(0, 2));
      drain($urandom_range(0, 2));
    end

    // Reset mid-COMPUTE.
    load_mats(1'b0, 0, 1'b0, t);
    repeat (2) step();
    reset_n = 1'b0;
    #1;
    chk("rst_cmp_vld", io.valid_o, 0);
    chk("rst_cmp_rdy", io.ready_o, 1);
    chk("rst_cmp_done", io.done_o, 0);
    step();
    reset_n = 1'b1;
    for (int n = 0; n < M*N; n++) c_m[n] = 0;
    drain(0);

    // Reset mid-DRAIN.
    for (int n = 0; n < MK; n++) a_m[n] = $urandom_range(1, 255);
    for (int n = 0; n < K*N; n++) b_m[n] = $urandom_range(1, 255);
    run_case(1'b0, 0, 1'b0, 1'b0, 0);
    io.flush_i = 1'b1;
    step();
    io.flush_i = 1'b0;
    io.yumi_i = 1'b1;
    step();
    io.yumi_i = 1'b0;
    chk("pre_rst_dat", io.data_o, 32'(c_m[1]));
    #2;
    reset_n = 1'b0;
    #1;
    chk("rst_drn_vld", io.valid_o, 0);
    chk("rst_drn_dat", io.data_o, 0);
    step();
    reset_n = 1'b1;
    for (int n = 0; n < M*N; n++) c_m[n] = 0;
    drain(0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
